// File: rtl/latsnq_seq_pkg.sv
// Shared types and constants for the latch-bank write sequencer.
// States, request opcodes and compile-time sizing helpers.
package latsnq_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_PRESET = 3'd4,
        ST_CHECK  = 3'd5
    } state_e;

    localparam logic OP_WRITE  = 1'b0;
    localparam logic OP_PRESET = 1'b1;

    // Bank address width; a single bank still gets one address bit.
    function automatic int addr_width(input int nbank);
        return (nbank > 1) ? $clog2(nbank) : 1;
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/latsnq_bank_wr_seq_if.sv
// Request/completion channel of the latch-bank write sequencer.
// master = requester, slave = sequencer.
interface latsnq_bank_wr_seq_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             valid;
    logic             ready;
    logic             op;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             done;
    logic             err;

    modport master (
        output valid, op, addr, data,
        input  ready, done, err
    );

    modport slave (
        input  valid, op, addr, data,
        output ready, done, err
    );
endinterface

// File: rtl/latsnq_seq_timer.sv
// Loadable down-counter that times each sequencer phase.
// Loading N gives N+1 cycles until the zero flag ends the phase.
module latsnq_seq_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          zero_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/latsnq_bank_wr_seq.sv
// Write/preset sequencer driving D, E and SETN of a latch-bank array.
// Optional read-back check of the strobed bank: define LATSNQ_SEQ_VERIFY_EN.
module latsnq_bank_wr_seq
    import latsnq_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NBANK      = 4,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1,
    parameter int PRESET_CYC = 2,
    localparam int AW        = addr_width(NBANK)
) (
    input  logic                   clk,
    input  logic                   rst,
    latsnq_bank_wr_seq_if.slave    req_if,
    output logic [WIDTH-1:0]       lat_d_o,
    output logic [NBANK-1:0]       lat_e_o,
    output logic [NBANK-1:0]       lat_setn_o
`ifdef LATSNQ_SEQ_VERIFY_EN
    ,
    input  logic [NBANK*WIDTH-1:0] lat_q_i
`endif
);

    // The first SETUP/PRESET cycle only registers the request, so those
    // phases run one cycle longer than the visible window they produce.
    localparam int MAXLEN = max_of4(SETUP_CYC + 1, PULSE_CYC, HOLD_CYC, PRESET_CYC + 1);
    localparam int TW     = $clog2(MAXLEN + 1);

    state_e           state_q;
    state_e           state_d;

    logic             op_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] data_q;
    logic             bad_q;

    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] lat_d_q;
    logic [NBANK-1:0] lat_e_q;
    logic [NBANK-1:0] lat_setn_q;

    logic             accept;
    logic             req_bad;
    logic             finish;
    logic             verify_fail;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_zero;
    logic [NBANK-1:0] bank_sel;

    assign accept  = (state_q == ST_IDLE) && ready_q && req_if.valid;
    assign req_bad = (32'(req_if.addr) >= NBANK);
    assign finish  = (state_q != ST_IDLE) && (state_d == ST_IDLE);

    // Decoded from the captured address, so an out-of-range request selects nothing.
    genvar gi;
    for (gi = 0; gi < NBANK; gi++) begin : g_bank_sel
        assign bank_sel[gi] = (32'(addr_q) == gi);
    end

    latsnq_seq_timer #(
        .TW (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

`ifdef LATSNQ_SEQ_VERIFY_EN
    logic [WIDTH-1:0] q_sel;
    logic [WIDTH-1:0] q_expect;

    always_comb begin
        q_sel = '0;
        for (int i = 0; i < NBANK; i++) begin
            if (bank_sel[i]) begin
                q_sel = q_sel | lat_q_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign q_expect    = (op_q == OP_PRESET) ? {WIDTH{1'b1}} : data_q;
    assign verify_fail = (state_q == ST_CHECK) && (q_sel != q_expect);
`else
    assign verify_fail = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    if (req_bad) begin
                        // One HOLD cycle without strobes carries the error to DONE.
                        state_d = ST_HOLD;
                        tmr_val = '0;
                    end else if (req_if.op == OP_PRESET) begin
                        state_d = ST_PRESET;
                        tmr_val = TW'(PRESET_CYC);
                    end else begin
                        state_d = ST_SETUP;
                        tmr_val = TW'(SETUP_CYC);
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PULSE_CYC - 1);
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
`ifdef LATSNQ_SEQ_VERIFY_EN
                    state_d = bad_q ? ST_IDLE : ST_CHECK;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_PRESET: begin
                if (tmr_zero) begin
`ifdef LATSNQ_SEQ_VERIFY_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_WRITE;
            addr_q <= '0;
            data_q <= '0;
            bad_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= req_if.op;
            addr_q <= req_if.addr;
            data_q <= req_if.data;
            bad_q  <= req_bad;
        end
    end

    // Strobes come only from captured registers and the decoded next state,
    // so nothing on the request inputs reaches the latch pins in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            lat_d_q    <= '0;
            lat_e_q    <= '0;
            lat_setn_q <= '1;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == ST_IDLE);
            done_q     <= finish;
            err_q      <= finish && (bad_q || verify_fail);
            if (state_q == ST_SETUP) begin
                lat_d_q <= data_q;
            end
            lat_e_q    <= (state_d == ST_PULSE) ? bank_sel : '0;
            lat_setn_q <= ((state_q == ST_PRESET) && (state_d == ST_PRESET)) ? ~bank_sel : '1;
        end
    end

    assign req_if.ready = ready_q;
    assign req_if.done  = done_q;
    assign req_if.err   = err_q;
    assign lat_d_o      = lat_d_q;
    assign lat_e_o      = lat_e_q;
    assign lat_setn_o   = lat_setn_q;

endmodule

// File: tb/tb_latsnq_bank_wr_seq.sv
// Scoreboard bench for latsnq_bank_wr_seq (NBANK=5 so addresses 5..7 are out of range).
// Build with LATSNQ_SEQ_VERIFY_EN to also exercise the read-back check.
`timescale 1ns/1ps
module tb_latsnq_bank_wr_seq;
    import latsnq_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int NBANK = 5;
    localparam int AW    = 3;
`ifdef LATSNQ_SEQ_VERIFY_EN
    localparam int XTRA  = 1;
`else
    localparam int XTRA  = 0;
`endif
    localparam int LAT_WR  = 5 + XTRA;
    localparam int LAT_PR  = 3 + XTRA;
    localparam int LAT_BAD = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    latsnq_bank_wr_seq_if #(.WIDTH(WIDTH), .AW(AW)) req_if ();
    logic [WIDTH-1:0] lat_d;
    logic [NBANK-1:0] lat_e;
    logic [NBANK-1:0] lat_setn;

`ifdef LATSNQ_SEQ_VERIFY_EN
    logic [NBANK*WIDTH-1:0] lat_q;
    logic [WIDTH-1:0]       q_mem [NBANK];
    logic [NBANK-1:0]       q_force0 = '0;

    initial for (int b = 0; b < NBANK; b++) q_mem[b] = '0;

    // Latch array model sampled mid-cycle; SETN dominates E.
    always @(negedge clk) begin
        for (int b = 0; b < NBANK; b++) begin
            if (!lat_setn[b]) q_mem[b] = '1;
            else if (lat_e[b]) q_mem[b] = lat_d;
        end
    end

    always_comb begin
        lat_q = '0;
        for (int b = 0; b < NBANK; b++) lat_q[b*WIDTH +: WIDTH] = q_force0[b] ? '0 : q_mem[b];
    end
`endif

    latsnq_bank_wr_seq #(
        .WIDTH(WIDTH), .NBANK(NBANK), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .PRESET_CYC(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_if     (req_if),
        .lat_d_o    (lat_d),
        .lat_e_o    (lat_e),
`ifdef LATSNQ_SEQ_VERIFY_EN
        .lat_setn_o (lat_setn),
        .lat_q_i    (lat_q)
`else
        .lat_setn_o (lat_setn)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    typedef struct { int cyc; logic err; logic [WIDTH-1:0] d; } done_t;
    typedef struct { int cyc; logic [NBANK-1:0] e; logic [NBANK-1:0] setn; logic [WIDTH-1:0] d; bit setup; } strb_t;
    done_t done_q [$];
    strb_t strb_q [$];

    // Monitor: strobe edges and DONE pulses are popped from the scoreboard as they appear.
    logic [NBANK-1:0] prev_e    = '0;
    logic [NBANK-1:0] prev_setn = '1;
    logic [WIDTH-1:0] prev_d    = '0;
    strb_t ev;
    done_t dv;
    always @(negedge clk) begin
        if (!rst) begin
            chk("e_setn_exclusive", 32'((|lat_e) && (|(~lat_setn))), 32'd0);
            chk("e_onehot0", 32'($onehot0(lat_e)), 32'd1);
            chk("setn_onehot0", 32'($onehot0(~lat_setn)), 32'd1);
            if ((|prev_e) && (|lat_e)) chk("d_stable_under_e", 32'(lat_d), 32'(prev_d));
            if ((lat_e !== prev_e) || (lat_setn !== prev_setn)) begin
                chk("strobe_expected", 32'(strb_q.size() > 0), 32'd1);
                if (strb_q.size() > 0) begin
                    ev = strb_q.pop_front();
                    chk("strobe_cycle", 32'(cyc), 32'(ev.cyc));
                    chk("strobe_e", 32'(lat_e), 32'(ev.e));
                    chk("strobe_setn", 32'(lat_setn), 32'(ev.setn));
                    chk("strobe_d", 32'(lat_d), 32'(ev.d));
                    if (ev.setup) chk("d_setup", 32'(prev_d), 32'(ev.d));
                end
            end
            if (req_if.done) begin
                chk("done_expected", 32'(done_q.size() > 0), 32'd1);
                if (done_q.size() > 0) begin
                    dv = done_q.pop_front();
                    $display("done @cyc %0d err=%0b d=%02h (expected cyc %0d err=%0b)", cyc, req_if.err, lat_d, dv.cyc, dv.err);
                    chk("done_cycle", 32'(cyc), 32'(dv.cyc));
                    chk("done_err", 32'(req_if.err), 32'(dv.err));
                    chk("done_lat_d", 32'(lat_d), 32'(dv.d));
                    chk("ready_at_done", 32'(req_if.ready), 32'd1);
                end
            end else begin
                chk("err_without_done", 32'(req_if.err), 32'd0);
            end
        end
        prev_e    = lat_e;
        prev_setn = lat_setn;
        prev_d    = lat_d;
    end

    typedef struct {
        logic             op;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic [NBANK-1:0] mask;
        bit               bad;
        bit               b2b;
    } vec_t;

    vec_t vecs [8] = '{
        '{OP_WRITE,  3'd2, 8'hA5, 5'b00100, 1'b0, 1'b0},
        '{OP_PRESET, 3'd1, 8'h00, 5'b00010, 1'b0, 1'b0},
        '{OP_WRITE,  3'd5, 8'hFF, 5'b00000, 1'b1, 1'b0},
        '{OP_WRITE,  3'd4, 8'h5A, 5'b10000, 1'b0, 1'b0},
        '{OP_PRESET, 3'd7, 8'h00, 5'b00000, 1'b1, 1'b0},
        '{OP_WRITE,  3'd0, 8'h11, 5'b00001, 1'b0, 1'b1},
        '{OP_PRESET, 3'd3, 8'h00, 5'b01000, 1'b0, 1'b1},
        '{OP_WRITE,  3'd1, 8'hC3, 5'b00010, 1'b0, 1'b0}
    };

    logic [WIDTH-1:0] last_d = '0;

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input vec_t v, output int acc, output int lat);
        int  n = 0;
        logic exp_err;
        req_if.valid = 1'b1;
        req_if.op    = v.op;
        req_if.addr  = v.addr;
        req_if.data  = v.data;
        while (!req_if.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 50), 32'd1);
        acc = -1;
        lat = 0;
        if (n < 50) begin
            acc = cyc + 1;
            exp_err = 1'b0;
`ifdef LATSNQ_SEQ_VERIFY_EN
            if (!v.bad) exp_err = q_force0[v.addr];
`endif
            if (v.bad) begin
                lat = LAT_BAD;
                done_q.push_back('{acc + LAT_BAD, 1'b1, last_d});
            end else if (v.op == OP_WRITE) begin
                lat = LAT_WR;
                strb_q.push_back('{acc + 2, v.mask, 5'h1F, v.data, 1'b1});
                strb_q.push_back('{acc + 4, 5'h00, 5'h1F, v.data, 1'b0});
                done_q.push_back('{acc + LAT_WR, exp_err, v.data});
                last_d = v.data;
            end else begin
                lat = LAT_PR;
                strb_q.push_back('{acc + 1, 5'h00, ~v.mask, last_d, 1'b0});
                strb_q.push_back('{acc + 3, 5'h00, 5'h1F, last_d, 1'b0});
                done_q.push_back('{acc + LAT_PR, exp_err, last_d});
            end
            $display("issue op=%0d addr=%0d data=%02h accepted @cyc %0d", v.op, v.addr, v.data, acc);
        end
        @(negedge clk);
        if (!v.b2b || acc < 0) req_if.valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((done_q.size() != 0 || strb_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(done_q.size() + strb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, lat, prev_acc, prev_lat, n;
        bit prev_b2b;
        vec_t v6;
        req_if.valid = 1'b0;
        req_if.op    = OP_WRITE;
        req_if.addr  = '0;
        req_if.data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_lat_e", 32'(lat_e), 32'h00);
        chk("rst_lat_setn", 32'(lat_setn), 32'h1F);
        chk("rst_lat_d", 32'(lat_d), 32'h00);
        chk("rst_ready", 32'(req_if.ready), 32'd0);
        chk("rst_done", 32'(req_if.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_if.ready), 32'd1);

        prev_b2b = 1'b0;
        prev_acc = 0;
        prev_lat = 0;
        foreach (vecs[i]) begin
            issue(vecs[i], acc, lat);
            if (prev_b2b) chk("b2b_spacing", 32'(acc - prev_acc), 32'(prev_lat + 1));
            prev_b2b = vecs[i].b2b;
            prev_acc = acc;
            prev_lat = lat;
            if (!vecs[i].b2b) begin
                drain();
                @(negedge clk);
            end
        end

        // Reset while E is high: strobe must drop at once and no DONE may follow.
        v6 = '{OP_WRITE, 3'd3, 8'h77, 5'b01000, 1'b0, 1'b0};
        issue(v6, acc, lat);
        n = 0;
        while (lat_e == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_seen", 32'(lat_e), 32'(5'b01000));
        #2 rst = 1'b1;
        #1;
        chk("midrst_lat_e", 32'(lat_e), 32'h00);
        chk("midrst_lat_setn", 32'(lat_setn), 32'h1F);
        chk("midrst_ready", 32'(req_if.ready), 32'd0);
        chk("midrst_done", 32'(req_if.done), 32'd0);
        done_q.delete();
        strb_q.delete();
        last_d = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_lat_d", 32'(lat_d), 32'h00);
        chk("postrst_ready", 32'(req_if.ready), 32'd1);
        repeat (8) @(negedge clk);

`ifdef LATSNQ_SEQ_VERIFY_EN
        // Bank 2 reads back as zero, so the check of 3C must flag an error.
        q_force0 = 5'b00100;
        v6 = '{OP_WRITE, 3'd2, 8'h3C, 5'b00100, 1'b0, 1'b0};
        issue(v6, acc, lat);
        drain();
        q_force0 = '0;
`endif
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
